// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe
//   Signed multiply-accumulate engine for the CNN datapath. It takes a stream of
//   (din0, din1) pairs framed by in_first/in_last, multiplies each pair through a
//   NUM_STAGE-deep pipeline and accumulates the products with saturation. Each
//   window produces one result: the accumulator is shifted right arithmetically
//   by SHIFT and then saturated to OUT_WIDTH.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   din0       signed operand A (activation), A_WIDTH bits
//   din1       signed operand B (weight), B_WIDTH bits
//   in_first   beat opens a new window
//   in_last    beat closes the window (may coincide with in_first)
//   out_valid  result valid
//   out_ready  downstream accepts when out_valid && out_ready
//   dout       signed scaled/saturated result, OUT_WIDTH bits
//   ovf        saturation happened somewhere in the window
//
// Handshake: a beat or result moves only on a clock edge where valid && ready.
// The whole pipeline advances together when the output register is empty or is
// being consumed (adv); otherwise every stage holds, including bubbles.

module cnn_mac_pipe #(
   parameter int A_WIDTH   = 24,
   parameter int B_WIDTH   = 8,
   parameter int ACC_WIDTH = 36,
   parameter int OUT_WIDTH = 24,
   parameter int NUM_STAGE = 2,
   parameter int SHIFT     = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   din0,
   input  logic [B_WIDTH-1:0]   din1,
   input  logic                 in_first,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] dout,
   output logic                 ovf
);

   localparam int PW  = A_WIDTH + B_WIDTH;
   localparam int AW1 = ACC_WIDTH + 1;
   // Wide enough to compare the shifted accumulator against the output limits
   // whichever of ACC_WIDTH / OUT_WIDTH is larger.
   localparam int MW  = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   logic                        adv;
   logic [NUM_STAGE-1:0]        vld_q, first_q, last_q;
   logic signed [PW-1:0]        prod_w;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        sticky_q, sticky_d;
   logic                        out_valid_q;
   logic [OUT_WIDTH-1:0]        dout_q, dout_d;
   logic                        ovf_q, ovf_d;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = reset && adv;
   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign ovf       = ovf_q;

   // ---------------- multiplier pipeline ----------------
   generate
      if (NUM_STAGE == 1) begin : g_one
         logic signed [PW-1:0] prod_q;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               prod_q <= '0;
            end else if (adv) begin
               prod_q <= $signed(din0) * $signed(din1);
            end
         end
         assign prod_w = prod_q;
      end else begin : g_multi
         logic signed [A_WIDTH-1:0] a_q;
         logic signed [B_WIDTH-1:0] b_q;
         logic signed [PW-1:0]      prod_q [2:NUM_STAGE];
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               a_q <= '0;
               b_q <= '0;
               for (int k = 2; k <= NUM_STAGE; k++) prod_q[k] <= '0;
            end else if (adv) begin
               a_q       <= din0;
               b_q       <= din1;
               prod_q[2] <= a_q * b_q;
               for (int k = 3; k <= NUM_STAGE; k++) prod_q[k] <= prod_q[k-1];
            end
         end
         assign prod_w = prod_q[NUM_STAGE];
      end
   endgenerate

   // Control bits travel alongside the data; index NUM_STAGE-1 is the
   // product stage feeding the accumulator.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q   <= '0;
         first_q <= '0;
         last_q  <= '0;
      end else if (adv) begin
         vld_q[0]   <= in_valid;
         first_q[0] <= in_first;
         last_q[0]  <= in_last;
         for (int k = 1; k < NUM_STAGE; k++) begin
            vld_q[k]   <= vld_q[k-1];
            first_q[k] <= first_q[k-1];
            last_q[k]  <= last_q[k-1];
         end
      end
   end

   // ---------------- accumulate and scale ----------------
   logic signed [AW1-1:0]       prod_ext, base, sum;
   logic signed [ACC_WIDTH-1:0] shifted;
   logic signed [MW-1:0]        sh_ext, out_max_ext, out_min_ext;
   logic                        acc_sat, out_sat;

   always_comb begin
      prod_ext    = {{(AW1-PW){prod_w[PW-1]}}, prod_w};
      base        = first_q[NUM_STAGE-1] ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
      sum         = base + prod_ext;
      // One guard bit: the top two bits differ exactly when the sum left range.
      acc_sat     = sum[AW1-1] != sum[AW1-2];
      if (acc_sat) acc_d = sum[AW1-1] ? ACC_MIN : ACC_MAX;
      else         acc_d = sum[ACC_WIDTH-1:0];
      sticky_d    = first_q[NUM_STAGE-1] ? acc_sat : (sticky_q | acc_sat);

      shifted     = acc_d >>> SHIFT;
      sh_ext      = {{(MW-ACC_WIDTH){shifted[ACC_WIDTH-1]}}, shifted};
      out_max_ext = {{(MW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
      out_min_ext = {{(MW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
      out_sat     = 1'b0;
      dout_d      = sh_ext[OUT_WIDTH-1:0];
      if (sh_ext > out_max_ext) begin
         dout_d  = OUT_MAX;
         out_sat = 1'b1;
      end else if (sh_ext < out_min_ext) begin
         dout_d  = OUT_MIN;
         out_sat = 1'b1;
      end
      ovf_d       = sticky_d | out_sat;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q    <= '0;
         sticky_q <= 1'b0;
      end else if (adv && vld_q[NUM_STAGE-1]) begin
         acc_q    <= acc_d;
         sticky_q <= sticky_d;
      end
   end

   // Output register: refills in the same cycle it is consumed, so back-to-back
   // results keep out_valid high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         ovf_q       <= 1'b0;
      end else if (adv) begin
         out_valid_q <= vld_q[NUM_STAGE-1] && last_q[NUM_STAGE-1];
         if (vld_q[NUM_STAGE-1] && last_q[NUM_STAGE-1]) begin
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
         end
      end
   end

endmodule

// File: doc/cnn_mac_pipe.md
Name: cnn_mac_pipe

Overview:
Parametrised signed multiply-accumulate engine that replaces fixed-width single-product multiplier wrappers in the CNN datapath. It streams (din0, din1) pairs framed by first/last flags and multiplies each pair through a NUM_STAGE-deep pipeline. Products are accumulated with saturation, and one scaled, saturated dot-product result is emitted per window (one convolution kernel or one dense-layer neuron). It sits between the line-buffer/weight-ROM readers and the activation/pool stage.

Parameters:
A_WIDTH, 24, signed width of din0 (activation).
B_WIDTH, 8, signed width of din1 (weight).
ACC_WIDTH, 36, signed accumulator width; must be >= A_WIDTH+B_WIDTH.
OUT_WIDTH, 24, signed width of dout.
NUM_STAGE, 2, multiplier pipeline depth (input register to product register); legal range 1..4.
SHIFT, 6, arithmetic right shift applied to the accumulator before output saturation; 0..ACC_WIDTH-1.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid && in_ready.
din0  in  A_WIDTH  signed operand A.
din1  in  B_WIDTH  signed operand B.
in_first  in  1  beat starts a new window.
in_last  in  1  beat ends the window; may coincide with in_first for a 1-tap window.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts when out_valid && out_ready.
dout  out  OUT_WIDTH  signed result.
ovf  out  1  saturation occurred anywhere in this window.

Behaviour:
- Reset (reset=0, async assert, sync deassert handled upstream): all pipeline valid bits 0, accumulator 0, sticky overflow 0, out_valid 0, dout 0, ovf 0. in_ready is 0 while reset is asserted and 1 on the first cycle after release.
- Global advance enable adv = !out_valid || out_ready. in_ready = adv. All pipeline registers (data, valid, first, last) update only when adv=1; otherwise they hold. No bubble-collapsing.
- Stages 1..NUM_STAGE: the operands are registered and multiplied; the full-precision signed product is A_WIDTH+B_WIDTH bits. Stage NUM_STAGE holds the product plus its valid/first/last bits.
- Accumulate stage (adv=1, product valid):
  - acc_next = first ? sext(prod) : acc + sext(prod).
  - The sum is computed at ACC_WIDTH+1 bits and saturated to ACC_WIDTH at the signed max/min.
  - The sticky flag is set on saturation. A first beat reinitialises the sticky flag to this beat's saturation only.
- When the product beat has last=1:
  - dout = sat_OUT_WIDTH(acc_next >>> SHIFT), arithmetic shift, truncation toward -inf.
  - ovf = sticky flag OR output saturation.
  - out_valid=1 on the following edge.
  - The accumulator keeps acc_next but is don't-care until the next first beat.
- Output register: dout/ovf hold stable while out_valid && !out_ready. When out_ready=1 and no new result arrives, out_valid clears. When a new result arrives in the same cycle as a consume, out_valid stays 1 with the new data; back-to-back 1-tap windows sustain full throughput.
- Latency: accepted last beat to out_valid = NUM_STAGE+1 cycles with no stall. Stalls add cycle-for-cycle.
- Framing errors:
  - A non-first beat with no open window accumulates onto the stale acc; this is defined, not flagged.
  - A first beat mid-window discards the partial sum.
- in_valid=0 cycles insert bubbles. Bubbles never alter acc or out_valid.
- Reset asserted mid-window or with out_valid=1 drops all in-flight beats and the pending result immediately.

Test Plan:
1. Defaults. 1-tap window: din0=1000, din1=-3, first=last=1, out_ready=1 -> out_valid exactly 3 cycles later, dout=-3000>>>6=-47, ovf=0.
2. 4-tap window (10,2),(20,3),(-5,4),(7,-1) with SHIFT=0 build -> single out_valid, dout=53, ovf=0. No out_valid on the intermediate beats.
3. Saturation: din0=0x7FFFFF, din1=127, 512 beats in one window -> acc clamps at 2^35-1, dout=0x7FFFFF, ovf=1. The next window (100,1) returns dout=1, ovf=0.
4. Backpressure: hold out_ready=0 while streaming three 1-tap windows -> in_ready drops once the first result is pending, dout holds stable, no result lost or duplicated. Release out_ready -> results appear in order.
5. Throughput: continuous 1-tap windows with out_ready=1 -> out_valid stays high every cycle after the initial NUM_STAGE+1 latency.
6. Assert reset low mid-window with out_valid=1 -> out_valid, dout, ovf go to 0 asynchronously. After release, a new window computes correctly with no residue from the prior partial sum.
